// File: rtl/drlp_pkg.sv
// Shared definitions for the DRLP read-path scheduler: packing modes,
// scheduler state encodings and the job-length legality rule.
package drlp_pkg;

    // Packing modes understood by drlp_rd_buffer.
    localparam logic [1:0] MODE_3X3 = 2'b00;
    localparam logic [1:0] MODE_4X4 = 2'b01;
    localparam logic [1:0] MODE_5X5 = 2'b10;
    localparam logic [1:0] MODE_6X6 = 2'b11;

    // Scheduler states.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Width of the length argument of len_legal; callers zero-extend into it.
    localparam int LEN_FN_W = 32;

    // A job length is legal when it is non-zero and a whole number of the
    // word groups the buffer emits for that mode: pairs for 3x3/6x6,
    // quads for 5x5, single words for 4x4.
    function automatic logic len_legal(input logic [1:0]          mode,
                                       input logic [LEN_FN_W-1:0] len);
        logic ok;
        ok = 1'b0;
        if (len != '0) begin
            case (mode)
                MODE_3X3, MODE_6X6: ok = ~len[0];
                MODE_4X4:           ok = 1'b1;
                MODE_5X5:           ok = (len[1:0] == 2'b00);
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/drlp_rd_sched_if.sv
// Scheduler <-> repacking-buffer bus: read enable, base address, packing
// mode, per-word ready and the end-of-job marker.
interface drlp_rd_sched_if #(
    parameter int DMA_ADDR_WIDTH = 32
);
    logic                      rd_dma;
    logic [DMA_ADDR_WIDTH-1:0] dma_base_addr;
    logic [1:0]                mode;
    logic                      buf_ready;
    logic                      last;

    // Scheduler side.
    modport master (
        output rd_dma, dma_base_addr, mode, last,
        input  buf_ready
    );

    // Buffer side.
    modport slave (
        input  rd_dma, dma_base_addr, mode, last,
        output buf_ready
    );
endinterface

// File: rtl/drlp_rr_arbiter.sv
// Round-robin first-set-bit picker. The pointer moves to winner+1 each time
// the caller consumes a pick, so every requester gets a turn.
module drlp_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_advance,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] cand;

    // Scan the slots starting at the pointer, wrapping; first set bit wins.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that leaves one unassigned would infer a latch.
        o_valid = 1'b0;
        o_idx   = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!o_valid && i_req[cand]) begin
                o_valid = 1'b1;
                o_idx   = cand;
            end
        end
    end

    assign ptr_d = i_advance ? IDX_W'((int'(o_idx) + 1) % NUM_REQ) : ptr_q;

    // Pointer register; restarts at requester 0.
    always_ff @(posedge i_clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples the pre-edge values.
        if (i_rst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/drlp_rd_sched.sv
// Read-path scheduler: shares drlp_rd_buffer between NUM_REQ loaders.
// Picks a job round-robin, validates its length against the packing mode,
// programs the buffer, counts packed words out, then drains and reports done.
module drlp_rd_sched
    import drlp_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DMA_ADDR_WIDTH = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int DRAIN_CYCLES   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*DMA_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]  i_req_len,
    input  logic [NUM_REQ*2-1:0]          i_req_mode,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [NUM_REQ-1:0]            o_err,
    output logic                          o_busy,
    drlp_rd_sched_if.master               bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DC_W  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    logic [1:0]                state_q, state_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;
    logic [DC_W-1:0]           drain_q, drain_d;
    logic [DMA_ADDR_WIDTH-1:0] base_q, base_d;
    logic [1:0]                mode_q, mode_d;
    logic [NUM_REQ-1:0]        grant_q, grant_d;
    logic [NUM_REQ-1:0]        done_q, done_d;
    logic [NUM_REQ-1:0]        err_q, err_d;
    logic                      rd_q, rd_d;

    logic [NUM_REQ-1:0]        arb_req;
    logic                      arb_valid;
    logic [IDX_W-1:0]          arb_idx;
    logic [NUM_REQ-1:0]        owner_oh;
    logic                      run_last;

    // A requester still shows its level in the cycle its done/err pulse is
    // visible; masking it there stops the finished job being picked again.
    assign arb_req = i_req & ~(done_q | err_q);

    drlp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (arb_req),
        .i_advance ((state_q == ST_IDLE) && arb_valid),
        .o_valid   (arb_valid),
        .o_idx     (arb_idx)
    );

    assign owner_oh = NUM_REQ'(1) << owner_q;
    assign run_last = (state_q == ST_RUN) && bus.buf_ready &&
                      (cnt_q == len_q - LEN_WIDTH'(1));

    // Next-state and output-register logic for the job FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        base_d  = base_q;
        mode_d  = mode_q;
        grant_d = grant_q;
        rd_d    = rd_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d = arb_idx;
                    base_d  = i_req_addr[arb_idx*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
                    len_d   = i_req_len[arb_idx*LEN_WIDTH +: LEN_WIDTH];
                    mode_d  = i_req_mode[arb_idx*2 +: 2];
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (len_legal(mode_q, LEN_FN_W'(len_q))) begin
                    grant_d = owner_oh;
                    rd_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    err_d   = owner_oh;
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_last) begin
                    rd_d    = 1'b0;
                    cnt_d   = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else if (bus.buf_ready) begin
                    cnt_d = cnt_q + LEN_WIDTH'(1);
                end
            end
            default: begin
                if (drain_q == DC_W'(DRAIN_CYCLES - 1)) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    drain_d = drain_q + DC_W'(1);
                end
            end
        endcase
    end

    // State and output registers; reset aborts any job in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            base_q  <= '0;
            mode_q  <= MODE_3X3;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    assign o_grant           = grant_q;
    assign o_done            = done_q;
    assign o_err             = err_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign bus.rd_dma        = rd_q;
    assign bus.dma_base_addr = base_q;
    assign bus.mode          = mode_q;
    assign bus.last          = run_last;

endmodule

// File: tb/tb_drlp_rd_sched.sv
// Directed bench for drlp_rd_sched: a table of single-requester jobs plus
// hand-written sequences for stray readies, request drop, reset mid-job,
// round-robin ordering and the maximum job length.
module tb_drlp_rd_sched;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int LW      = 16;
    localparam int DRAIN   = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*AW-1:0] addr_v;
    logic [NUM_REQ*LW-1:0] len_v;
    logic [NUM_REQ*2-1:0] mode_v;
    logic                 rdy;
    logic [NUM_REQ-1:0]   grant, done, err;
    logic                 busy;

    int n_cmp  = 0;
    int n_fail = 0;

    drlp_rd_sched_if #(.DMA_ADDR_WIDTH(AW)) bus ();
    assign bus.buf_ready = rdy;

    drlp_rd_sched #(
        .NUM_REQ        (NUM_REQ),
        .DMA_ADDR_WIDTH (AW),
        .LEN_WIDTH      (LW),
        .DRAIN_CYCLES   (DRAIN)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_req_addr (addr_v),
        .i_req_len  (len_v),
        .i_req_mode (mode_v),
        .o_grant    (grant),
        .o_done     (done),
        .o_err      (err),
        .o_busy     (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] len;
        bit          ok;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the active edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One job on requester k from an idle scheduler; checks timing end to end.
    task automatic run_job(input int k, input logic [31:0] a, input logic [15:0] l,
                           input logic [1:0] m, input bit ok, input bit drop_req,
                           input bit stray, input string nm);
        logic [NUM_REQ-1:0] oh;
        int last_at;
        int rd_low;
        int t;
        bit seen;
        oh = '0;
        oh[k] = 1'b1;
        // Cycle 0: request presented in IDLE.
        tick();
        addr_v[k*AW +: AW] = a;
        len_v[k*LW +: LW]  = l;
        mode_v[k*2 +: 2]   = m;
        req[k] = 1'b1;
        rdy = stray;
        #1;
        check({nm, " idle_busy"}, 64'(busy), 64'(0));
        // Cycle 1: CHECK, job registers latched.
        tick();
        rdy = stray;
        #1;
        check({nm, " base"}, 64'(bus.dma_base_addr), 64'(a));
        check({nm, " mode"}, 64'(bus.mode), 64'(m));
        check({nm, " check_rd"}, 64'(bus.rd_dma), 64'(0));
        // Cycle 2: RUN with read enable, or error pulse.
        tick();
        rdy = 1'b0;
        #1;
        if (!ok) begin
            check({nm, " err"}, 64'(err), 64'(oh));
            check({nm, " err_rd"}, 64'(bus.rd_dma), 64'(0));
            check({nm, " err_grant"}, 64'(grant), 64'(0));
            req[k] = 1'b0;
            tick();
            #1;
            check({nm, " err_pulse_end"}, 64'(err), 64'(0));
            check({nm, " err_idle"}, 64'(busy), 64'(0));
            return;
        end
        check({nm, " rd_rise"}, 64'(bus.rd_dma), 64'(1));
        check({nm, " grant"}, 64'(grant), 64'(oh));
        last_at = -1;
        rd_low  = 0;
        for (int i = 0; i < int'(l); i++) begin
            if (i > 0) tick();
            rdy = 1'b1;
            if (drop_req && i == 0) req[k] = 1'b0;
            #1;
            if (bus.last && last_at < 0) last_at = i;
            if (!bus.rd_dma) rd_low++;
        end
        check({nm, " last_index"}, 64'(last_at), 64'(int'(l) - 1));
        check({nm, " rd_held"}, 64'(rd_low), 64'(0));
        // Drain: rd drops at once, done after DRAIN cycles of DRAIN state.
        t = 0;
        seen = 1'b0;
        while (!seen && t < 12) begin
            tick();
            rdy = stray;
            #1;
            t++;
            if (t == 1) begin
                check({nm, " rd_fall"}, 64'(bus.rd_dma), 64'(0));
                check({nm, " drain_grant"}, 64'(grant), 64'(oh));
            end
            if (done != '0) seen = 1'b1;
        end
        check({nm, " done_latency"}, 64'(t), 64'(DRAIN + 1));
        check({nm, " done"}, 64'(done), 64'(oh));
        check({nm, " done_grant"}, 64'(grant), 64'(0));
        check({nm, " done_busy"}, 64'(busy), 64'(0));
        rdy = 1'b0;
        req[k] = 1'b0;
    endtask

    initial begin
        logic [7:0] ord;
        int n_g;
        int jobs;
        int multi;
        int idle_run;
        logic [NUM_REQ-1:0] prev_g;

        vecs[0]  = '{2'b01, 16'd4, 1'b1};
        vecs[1]  = '{2'b10, 16'd6, 1'b0};
        vecs[2]  = '{2'b10, 16'd8, 1'b1};
        vecs[3]  = '{2'b00, 16'd2, 1'b1};
        vecs[4]  = '{2'b00, 16'd3, 1'b0};
        vecs[5]  = '{2'b11, 16'd5, 1'b0};
        vecs[6]  = '{2'b11, 16'd6, 1'b1};
        vecs[7]  = '{2'b01, 16'd1, 1'b1};
        vecs[8]  = '{2'b00, 16'd0, 1'b0};
        vecs[9]  = '{2'b01, 16'd0, 1'b0};
        vecs[10] = '{2'b10, 16'd4, 1'b1};
        vecs[11] = '{2'b10, 16'd2, 1'b0};

        rst = 1'b1;
        req = '0;
        addr_v = '0;
        len_v = '0;
        mode_v = '0;
        rdy = 1'b0;
        repeat (3) tick();
        check("rst grant", 64'(grant), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst err", 64'(err), 64'(0));
        check("rst rd", 64'(bus.rd_dma), 64'(0));
        check("rst busy", 64'(busy), 64'(0));
        check("rst base", 64'(bus.dma_base_addr), 64'(0));
        check("rst mode", 64'(bus.mode), 64'(0));
        check("rst last", 64'(bus.last), 64'(0));
        tick();
        rst = 1'b0;

        // Basic job from the test plan.
        run_job(0, 32'h100, 16'd4, 2'b01, 1'b1, 1'b0, 1'b0, "basic");

        // Length-legality table, alternating requester slots.
        for (int i = 0; i < 12; i++)
            run_job(i % 2, 32'h1000 + 32'(i * 16), vecs[i].len, vecs[i].mode,
                    vecs[i].ok, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Stray readies in IDLE, CHECK and DRAIN are never counted.
        run_job(1, 32'h3000, 16'd2, 2'b00, 1'b1, 1'b0, 1'b1, "stray");
        // Request dropped in RUN still completes.
        run_job(0, 32'h4000, 16'd6, 2'b11, 1'b1, 1'b1, 1'b0, "drop");

        // Reset after 3 of 8 words; pointer is 1 at this point.
        tick();
        addr_v[0 +: AW] = 32'h2000;
        len_v[0 +: LW]  = 16'd8;
        mode_v[0 +: 2]  = 2'b01;
        req = 2'b01;
        tick();
        tick();
        rdy = 1'b1;
        tick();
        tick();
        tick();
        rdy = 1'b0;
        rst = 1'b1;
        req = '0;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst grant", 64'(grant), 64'(0));
        check("mid_rst done", 64'(done), 64'(0));
        check("mid_rst err", 64'(err), 64'(0));
        check("mid_rst rd", 64'(bus.rd_dma), 64'(0));
        check("mid_rst busy", 64'(busy), 64'(0));
        check("mid_rst base", 64'(bus.dma_base_addr), 64'(0));
        check("mid_rst mode", 64'(bus.mode), 64'(0));

        // Round robin with both requests held: order 0,1,0,1 (pointer reset to 0).
        addr_v = {32'h6000, 32'h5000};
        len_v  = {16'd2, 16'd2};
        mode_v = {2'b00, 2'b00};
        req = 2'b11;
        ord = 8'hFF;
        n_g = 0;
        jobs = 0;
        multi = 0;
        prev_g = '0;
        for (int c = 0; c < 200 && jobs < 4; c++) begin
            tick();
            rdy = bus.rd_dma;
            #1;
            if ($countones(grant) > 1) multi++;
            if (grant != '0 && prev_g == '0) begin
                if (n_g < 4) ord[2*n_g +: 2] = (grant == 2'b01) ? 2'd0 : 2'd1;
                n_g++;
            end
            prev_g = grant;
            if (done != '0) jobs++;
        end
        check("rr jobs_done", 64'(jobs), 64'(4));
        check("rr order", 64'(ord), 64'(8'h44));
        check("rr onehot", 64'(multi), 64'(0));
        req = '0;
        idle_run = 0;
        for (int c = 0; c < 60 && idle_run < 3; c++) begin
            tick();
            rdy = bus.rd_dma;
            #1;
            if (!busy) idle_run++;
            else idle_run = 0;
        end
        check("rr settle", 64'(idle_run), 64'(3));
        rdy = 1'b0;

        // Maximum length completes without counter wrap.
        run_job(1, 32'hFFFF_FFF0, 16'hFFFF, 2'b01, 1'b1, 1'b0, 1'b0, "maxlen");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
